serial_byte_deser: RTL
======================

# serial_byte_deser

Serial-in, parallel-out byte deserializer that sits directly downstream of the 8-bit PISO serializer. It samples the MSB-first serial stream the PISO drives on its `sout`, qualified by a bit-valid strobe, and assembles `NBITS`-bit words. Each completed word is presented on a valid/ready output port backed by a one-entry buffer. A sticky overflow flag reports words lost to backpressure.

## Interface
- `NBITS`, default 8: word width and bits per frame; legal values 2..32.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sin_val`  in  1  serial bit valid; `sin` is sampled only when this is high.
- `sin`  in  1  serial data bit, MSB first; connects to the PISO `sout`.
- `sync`  in  1  frame restart; discards any partial word.
- `out_val`  out  1  output buffer holds a word.
- `out_rdy`  in  1  consumer accepts the word; a transfer occurs when `out_val` and `out_rdy` are both high.
- `out_data`  out  NBITS  assembled word; first received bit lands in `out_data[NBITS-1]`.
- `overflow`  out  1  sticky: a completed word was dropped.

## Operation
- Internal state:
  - shift register `sreg[NBITS-1:0]`
  - bit counter `cnt` of width `$clog2(NBITS)`
  - FSM with states IDLE (`cnt==0`, no partial word) and RECV (`1 <= cnt <= NBITS-1`)
  - output buffer `obuf`, `out_val`, `overflow`
- Bit accept, when `sin_val=1` and `sync=0`:
  - `sreg <= {sreg[NBITS-2:0], sin}` and `cnt <= cnt+1`.
  - IDLE→RECV on the first bit.
- Word complete: a bit is accepted while `cnt==NBITS-1`.
  - The completed word `{sreg[NBITS-2:0], sin}` is offered to the buffer.
  - `cnt` wraps to 0 and the FSM goes RECV→IDLE.
  - The next accepted bit starts a new word with no dead cycle.
- `sync=1`, `sin_val=0`: `cnt <= 0`, `sreg <= 0`, FSM→IDLE; no word is produced.
- `sync=1`, `sin_val=1`: the partial word is discarded and `sin` becomes bit 0 of a new frame.
  - `sreg <= {0..., sin}`, `cnt <= 1`, FSM→RECV.
  - When `NBITS` bits have been received since `sync`, the word completes normally.
- Buffer load on completion:
  - Loads if the buffer is empty, or if it is full and drained in the same cycle (`out_val && out_rdy`). `out_val` is then 1 next cycle.
  - If the buffer is full and not drained, the new word is dropped, `overflow <= 1`, and the buffered word is kept unchanged.
- Drain with no completion in the same cycle: `out_val <= 0`.
- `overflow` clears only on reset.
- `out_data` is driven from `obuf` only; it holds its last value while `out_val=0`.

## Timing
- Reset values: `out_val=0`, `out_data=0`, `overflow=0`, `cnt=0`, `sreg=0`, FSM=IDLE.
- Reset takes priority over every other input.
- Reset mid-frame discards the partial word and any buffered word.
- Latency: the final bit is accepted at edge N, and `out_val`/`out_data` are valid after edge N.
- Throughput: one word per `NBITS` accepted bits. With `out_rdy` held at 1, back-to-back words never overflow.
- `sin_val` gaps of any length pause assembly without losing bits.
- `out_rdy` is allowed to be high while `out_val=0`; this has no effect.
- No combinational path from any input to any output.

## Structure
- Shared package `serial_pkg` contains:
  - `SER_NBITS_DEFAULT = 8`
  - function `ser_cnt_w(n) = $clog2(n)`
  - enum `deser_state_e {DESER_IDLE, DESER_RECV}`
  - The PISO serializer uses the same package.
- One sub-module, `deser_out_buf`: a one-entry valid/ready buffer with parameter `NBITS`.
  - Inputs: `in_val`, `in_data`.
  - Outputs: `out_val`/`out_data`, and a `drop` pulse that feeds the overflow flag.
- The shift register, counter and FSM live in the top module.

## Test plan
- Reset, then bits of 0xA5 MSB-first on 8 consecutive cycles with `out_rdy=1` → `out_val` high for one cycle after the 8th edge, `out_data=0xA5`, `overflow=0`.
- Same word 0x3C with `sin_val` gaps of 0–3 cycles between random bits → a single word 0x3C is produced.
- Words 0x11 then 0x22 back-to-back, with `out_rdy=0` until both are complete → `out_data` stays 0x11, `overflow=1`. After `out_rdy=1` for one cycle, `out_val=0` and `overflow` remains 1.
- Word 0x80 completes in the same cycle that buffered 0x7F drains → next cycle `out_val=1`, `out_data=0x80`, no overflow.
- 5 bits sent, then `sync` with `sin_val` and `sin=1`, then bits of 0x5A's low 7 bits → `out_data=0xDA`, with no word emitted for the partial frame.
- Reset asserted after 4 bits of a frame with a word buffered → `out_val=0`, `out_data=0`, `overflow=0`. The following 8 bits of 0xF0 yield `out_data=0xF0`.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link blocks (PISO serializer and
// SIPO byte deserializer): default word width, counter sizing helper and
// the deserializer state type.
package serial_pkg;

    localparam int SER_NBITS_DEFAULT = 8;

    // Width of a bit counter that has to count 0..n-1.
    function automatic int ser_cnt_w(input int n);
        return $clog2(n);
    endfunction

    typedef enum logic [0:0] {
        DESER_IDLE = 1'b0,
        DESER_RECV = 1'b1
    } deser_state_e;

endpackage

// File: rtl/deser_out_buf.sv
// One-entry valid/ready holding buffer for completed words. A new word is
// accepted when the entry is free or is being drained in the same cycle;
// otherwise it is discarded and a single-cycle drop pulse is raised.
module deser_out_buf #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    input  logic [NBITS-1:0] in_data,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_data,
    output logic             drop
);

    logic             val_q, val_d;
    logic [NBITS-1:0] data_q, data_d;
    logic             drain;
    logic             load;

    // Decide whether the incoming word loads, is dropped, or the entry empties.
    always_comb begin
        drain  = val_q & out_rdy;
        load   = in_val & (~val_q | drain);
        drop   = in_val & val_q & ~drain;
        val_d  = val_q;
        data_d = data_q;
        if (load) begin
            val_d  = 1'b1;
            data_d = in_data;
        end else if (drain) begin
            val_d  = 1'b0;
        end
    end

    // Entry register; data is left untouched on drain so out_data holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            val_q  <= 1'b0;
            data_q <= '0;
        end else begin
            val_q  <= val_d;
            data_q <= data_d;
        end
    end

    assign out_val  = val_q;
    assign out_data = data_q;

endmodule

// File: rtl/serial_byte_deser.sv
// Serial-in, parallel-out deserializer. Samples an MSB-first bit stream
// qualified by sin_val, assembles NBITS-bit words, and hands each complete
// word to a one-entry output buffer. Words lost because the buffer was
// still full are recorded in a sticky overflow flag.
module serial_byte_deser
    import serial_pkg::*;
#(
    parameter int NBITS = SER_NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin_val,
    input  logic             sin,
    input  logic             sync,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_data,
    output logic             overflow
);

    localparam int CW = ser_cnt_w(NBITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

    logic [NBITS-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    deser_state_e     state_q, state_d;
    logic             overflow_q;

    logic             word_val;
    logic [NBITS-1:0] word_data;
    logic             drop;

    // The word being completed always includes the bit arriving this cycle.
    assign word_data = {sreg_q[NBITS-2:0], sin};

    // Shift/count/state next-state; sync restarts the frame and takes
    // precedence over a normal shift, reusing a simultaneous bit as bit 0.
    always_comb begin
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        word_val = 1'b0;
        if (sin_val && sync) begin
            sreg_d  = {{(NBITS-1){1'b0}}, sin};
            cnt_d   = CW'(1);
            state_d = DESER_RECV;
        end else if (sin_val) begin
            sreg_d = word_data;
            if (state_q == DESER_RECV && cnt_q == LAST_BIT) begin
                cnt_d    = '0;
                state_d  = DESER_IDLE;
                word_val = 1'b1;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                state_d = DESER_RECV;
            end
        end else if (sync) begin
            sreg_d  = '0;
            cnt_d   = '0;
            state_d = DESER_IDLE;
        end
    end

    // Assembly registers and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q     <= '0;
            cnt_q      <= '0;
            state_q    <= DESER_IDLE;
            overflow_q <= 1'b0;
        end else begin
            sreg_q     <= sreg_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            overflow_q <= overflow_q | drop;
        end
    end

    deser_out_buf #(
        .NBITS(NBITS)
    ) u_out_buf (
        .clk      (clk),
        .reset    (reset),
        .in_val   (word_val),
        .in_data  (word_data),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .drop     (drop)
    );

    assign overflow = overflow_q;

endmodule
